// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution block.
// Holds the MIPS opcode, REGIMM rt and SPECIAL func encodings used by
// decode, the instruction-type tags, the FSM state encoding, and the
// default datapath width, tag width and exception vector.
package branch_resolve_pkg;

  localparam int          DATA_WIDTH      = 32;
  localparam int          BRANCH_ID_BIT   = 6;
  localparam logic [31:0] EXCEPTION_ENTRY = 32'hBFC00380;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  // REGIMM rt field
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // SPECIAL func field
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  typedef enum logic [3:0] {
    INSTR_TYPE_NONE,
    INSTR_TYPE_BEQ,
    INSTR_TYPE_BNE,
    INSTR_TYPE_BLEZ,
    INSTR_TYPE_BGTZ,
    INSTR_TYPE_BLTZ,
    INSTR_TYPE_BGEZ,
    INSTR_TYPE_BLTZAL,
    INSTR_TYPE_BGEZAL,
    INSTR_TYPE_J,
    INSTR_TYPE_JAL,
    INSTR_TYPE_JR,
    INSTR_TYPE_JALR
  } instr_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DS,
    ST_REQ
  } state_t;

  // Maps a raw instruction word onto its branch type tag.
  function automatic instr_type_t decode_type(input logic [31:0] instr);
    instr_type_t t;
    t = INSTR_TYPE_NONE;
    unique case (instr[31:26])
      OP_BEQ:  t = INSTR_TYPE_BEQ;
      OP_BNE:  t = INSTR_TYPE_BNE;
      OP_BLEZ: t = INSTR_TYPE_BLEZ;
      OP_BGTZ: t = INSTR_TYPE_BGTZ;
      OP_J:    t = INSTR_TYPE_J;
      OP_JAL:  t = INSTR_TYPE_JAL;
      OP_REGIMM: begin
        case (instr[20:16])
          RT_BLTZ:   t = INSTR_TYPE_BLTZ;
          RT_BGEZ:   t = INSTR_TYPE_BGEZ;
          RT_BLTZAL: t = INSTR_TYPE_BLTZAL;
          RT_BGEZAL: t = INSTR_TYPE_BGEZAL;
          default:   t = INSTR_TYPE_NONE;
        endcase
      end
      OP_SPECIAL: begin
        case (instr[5:0])
          FN_JR:   t = INSTR_TYPE_JR;
          FN_JALR: t = INSTR_TYPE_JALR;
          default: t = INSTR_TYPE_NONE;
        endcase
      end
      default: t = INSTR_TYPE_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// branch_cond_eval: combinational decode, condition evaluation, target
// and link computation for one branch/jump instruction.
// Ports: instr_i/pc_i/rs_i/rt_i in; is_branch_o, taken_o, exc_o,
// target_o, link_en_o, link_reg_o out.
// Optional macro BR_ALIGN_CHECK_EN: a taken branch with a misaligned
// target raises exc_o; without it exc_o is tied low.
module branch_cond_eval
  import branch_resolve_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0] rt_i,
  output logic                  is_branch_o,
  output logic                  taken_o,
  output logic                  exc_o,
  output logic [DATA_WIDTH-1:0] target_o,
  output logic                  link_en_o,
  output logic [4:0]            link_reg_o
);

  localparam logic signed [DATA_WIDTH-1:0] ZERO = '0;

  instr_type_t                  itype;
  logic signed [DATA_WIDTH-1:0] rs_s;
  logic [DATA_WIDTH-1:0]        pc4;
  logic [DATA_WIDTH-1:0]        br_tgt;
  logic [DATA_WIDTH-1:0]        jmp_tgt;

  assign itype   = decode_type(instr_i);
  assign rs_s    = rs_i;
  assign pc4     = pc_i + DATA_WIDTH'(4);
  assign br_tgt  = pc4 + {{(DATA_WIDTH-18){instr_i[15]}}, instr_i[15:0], 2'b00};
  assign jmp_tgt = {pc4[DATA_WIDTH-1:28], instr_i[25:0], 2'b00};

  always_comb begin
    is_branch_o = 1'b1;
    taken_o     = 1'b0;
    target_o    = br_tgt;
    link_en_o   = 1'b0;
    link_reg_o  = 5'd31;
    unique case (itype)
      INSTR_TYPE_BEQ:    taken_o = (rs_i == rt_i);
      INSTR_TYPE_BNE:    taken_o = (rs_i != rt_i);
      INSTR_TYPE_BLEZ:   taken_o = (rs_s <= ZERO);
      INSTR_TYPE_BGTZ:   taken_o = (rs_s >  ZERO);
      INSTR_TYPE_BLTZ:   taken_o = (rs_s <  ZERO);
      INSTR_TYPE_BGEZ:   taken_o = (rs_s >= ZERO);
      INSTR_TYPE_BLTZAL: begin
        taken_o   = (rs_s < ZERO);
        link_en_o = 1'b1;
      end
      INSTR_TYPE_BGEZAL: begin
        taken_o   = (rs_s >= ZERO);
        link_en_o = 1'b1;
      end
      INSTR_TYPE_J: begin
        taken_o  = 1'b1;
        target_o = jmp_tgt;
      end
      INSTR_TYPE_JAL: begin
        taken_o   = 1'b1;
        target_o  = jmp_tgt;
        link_en_o = 1'b1;
      end
      INSTR_TYPE_JR: begin
        taken_o  = 1'b1;
        target_o = rs_i;
      end
      INSTR_TYPE_JALR: begin
        taken_o    = 1'b1;
        target_o   = rs_i;
        link_en_o  = 1'b1;
        link_reg_o = instr_i[15:11];
      end
      default: is_branch_o = 1'b0;
    endcase
  end

`ifdef BR_ALIGN_CHECK_EN
  assign exc_o = is_branch_o & taken_o & (target_o[1:0] != 2'b00);
`else
  assign exc_o = 1'b0;
`endif

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: producer of the branch redirect handshake for fetch.
// Accepts a branch/jump from execute (in_valid/in_ready), emits a one-cycle
// link pulse (link_valid/link_reg/link_data) at accept, waits for the
// matching delay slot (ds_valid/ds_branch_id), then holds branch_valid with
// is_taken/has_exception/br_target until branch_ready. flush abandons any
// held branch. Optional macro BR_ALIGN_CHECK_EN enables target alignment
// exceptions.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    BRANCH_ID_BIT = 6,
  parameter logic [DATA_WIDTH-1:0] EXC_ENTRY     = 32'hBFC00380
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_rs,
  input  logic [DATA_WIDTH-1:0]    in_rt,
  input  logic [BRANCH_ID_BIT-1:0] in_branch_id,
  input  logic                     ds_valid,
  input  logic [BRANCH_ID_BIT-1:0] ds_branch_id,
  input  logic                     flush,
  output logic                     branch_valid,
  input  logic                     branch_ready,
  output logic                     is_taken,
  output logic                     has_exception,
  output logic [DATA_WIDTH-1:0]    br_target,
  output logic                     link_valid,
  output logic [4:0]               link_reg,
  output logic [DATA_WIDTH-1:0]    link_data
);

  state_t                   state_q, state_d;
  logic                     taken_q, exc_q;
  logic [DATA_WIDTH-1:0]    target_q;
  logic [BRANCH_ID_BIT-1:0] id_q;

  logic                     ev_is_branch, ev_taken, ev_exc, ev_link_en;
  logic [DATA_WIDTH-1:0]    ev_target;
  logic [4:0]               ev_link_reg;
  logic                     accept, br_accept, ds_now, ds_held;

  branch_cond_eval #(.DATA_WIDTH(DATA_WIDTH)) u_eval (
    .instr_i     (in_instr),
    .pc_i        (in_pc),
    .rs_i        (in_rs),
    .rt_i        (in_rt),
    .is_branch_o (ev_is_branch),
    .taken_o     (ev_taken),
    .exc_o       (ev_exc),
    .target_o    (ev_target),
    .link_en_o   (ev_link_en),
    .link_reg_o  (ev_link_reg)
  );

  // flush and reset both win over a same-cycle accept
  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid & in_ready & ~flush & ~rst;
  assign br_accept = accept & ev_is_branch;
  assign ds_now    = ds_valid & (ds_branch_id == in_branch_id);
  assign ds_held   = ds_valid & (ds_branch_id == id_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (br_accept) begin
          if (ds_now) state_d = (ev_taken | ev_exc) ? ST_REQ : ST_IDLE;
          else        state_d = ST_WAIT_DS;
        end
      end
      ST_WAIT_DS: begin
        if (ds_held) state_d = (taken_q | exc_q) ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (branch_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      taken_q  <= 1'b0;
      exc_q    <= 1'b0;
      target_q <= '0;
      id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (br_accept) begin
        taken_q  <= ev_taken;
        exc_q    <= ev_exc;
        target_q <= ev_target;
        id_q     <= in_branch_id;
      end
    end
  end

  // redirect outputs are only meaningful, and only non-zero, while in REQ
  assign branch_valid  = (state_q == ST_REQ);
  assign has_exception = branch_valid & exc_q;
  assign is_taken      = branch_valid & taken_q & ~exc_q;
  assign br_target     = !branch_valid ? '0 : (exc_q ? EXC_ENTRY : target_q);

  assign link_valid = accept & ev_is_branch & ev_link_en;
  assign link_reg   = link_valid ? ev_link_reg : 5'd0;
  assign link_data  = link_valid ? (in_pc + DATA_WIDTH'(8)) : '0;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam logic [31:0] EXC = 32'hBFC00380;

  typedef struct packed {
    logic        taken;
    logic        exc;
    logic [31:0] target;
  } redir_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ds_valid, flush, branch_ready;
  logic [31:0] in_instr, in_pc, in_rs, in_rt, br_target, link_data;
  logic [5:0]  in_branch_id, ds_branch_id;
  logic        branch_valid, is_taken, has_exception, link_valid;
  logic [4:0]  link_reg;

  int total = 0;
  int bad   = 0;
  redir_t exp_q[$];

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt),
    .in_branch_id(in_branch_id), .ds_valid(ds_valid), .ds_branch_id(ds_branch_id),
    .flush(flush), .branch_valid(branch_valid), .branch_ready(branch_ready),
    .is_taken(is_taken), .has_exception(has_exception), .br_target(br_target),
    .link_valid(link_valid), .link_reg(link_reg), .link_data(link_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completed handshake pops and checks one expected redirect.
  always @(negedge clk) begin
    if (!rst && branch_valid && branch_ready) begin
      if (exp_q.size() == 0) chk("unexpected_redirect", 1, 0);
      else begin
        redir_t e;
        e = exp_q.pop_front();
        chk("sb_taken",  is_taken,      e.taken);
        chk("sb_exc",    has_exception, e.exc);
        chk("sb_target", br_target,     e.target);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle; optionally with its delay slot.
  task automatic accept(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [5:0] id, input logic ds_same,
                        input logic exp_lv, input logic [4:0] exp_lr,
                        input logic [31:0] exp_ld, input string tag);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs = rs; in_rt = rt;
    in_branch_id = id; ds_valid = ds_same; ds_branch_id = id;
    #1;
    chk({tag, "_link_valid"}, link_valid, exp_lv);
    chk({tag, "_link_reg"},   link_reg,   exp_lr);
    chk({tag, "_link_data"},  link_data,  exp_ld);
    tick();
    in_valid = 1'b0; ds_valid = 1'b0;
  endtask

  task automatic ds(input logic [5:0] id);
    ds_valid = 1'b1; ds_branch_id = id;
    tick();
    ds_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    branch_ready = 1'b1;
    tick();
    branch_ready = 1'b0;
    chk({tag, "_bv_drop"}, branch_valid, 0);
    chk({tag, "_ready"},   in_ready,     1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs = '0; in_rt = '0;
    in_branch_id = '0; ds_valid = 1'b0; ds_branch_id = '0; flush = 1'b0; branch_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bv",       branch_valid, 0);
    chk("rst_taken",    is_taken, 0);
    chk("rst_exc",      has_exception, 0);
    chk("rst_target",   br_target, 0);
    chk("rst_link",     link_valid, 0);
    rst = 1'b0;
    tick();

    // BEQ taken, delay slot two cycles after accept
    accept({6'h04, 5'd1, 5'd2, 16'h0004}, 32'h00400000, 5, 5, 3, 0, 0, 0, 0, "beq");
    chk("beq_wait_ready", in_ready, 0);
    tick();
    chk("beq_no_bv_early", branch_valid, 0);
    ds(3);
    chk("beq_bv", branch_valid, 1);
    chk("beq_taken", is_taken, 1);
    chk("beq_target", br_target, 32'h00400014);
    exp_q.push_back('{1'b1, 1'b0, 32'h00400014});
    handshake("beq");

    // BNE not taken; foreign delay-slot tag ignored
    accept({6'h05, 5'd1, 5'd2, 16'h0010}, 32'h00400100, 7, 7, 4, 0, 0, 0, 0, "bne");
    ds(9);
    chk("bne_ignore_ds", in_ready, 0);
    ds(4);
    chk("bne_no_bv", branch_valid, 0);
    chk("bne_ready", in_ready, 1);

    // JAL, delay slot seen at accept; outputs stable while not ready
    accept({6'h03, 26'h0000400}, 32'h80001000, 0, 0, 5, 1, 1, 31, 32'h80001008, "jal");
    exp_q.push_back('{1'b1, 1'b0, 32'h80001000});
    for (int i = 0; i < 4; i++) begin
      chk("jal_hold_bv", branch_valid, 1);
      chk("jal_hold_target", br_target, 32'h80001000);
      tick();
    end
    handshake("jal");

    // BLTZAL taken to pc, then not taken with link pulse still present
    accept({6'h01, 5'd3, 5'h10, 16'hFFFF}, 32'h00400200, 32'hFFFFFFFF, 0, 6, 1, 1, 31, 32'h00400208, "bltzal_t");
    chk("bltzal_t_bv", branch_valid, 1);
    exp_q.push_back('{1'b1, 1'b0, 32'h00400200});
    handshake("bltzal_t");
    accept({6'h01, 5'd3, 5'h10, 16'hFFFF}, 32'h00400300, 0, 0, 7, 1, 1, 31, 32'h00400308, "bltzal_nt");
    chk("bltzal_nt_bv", branch_valid, 0);
    chk("bltzal_nt_ready", in_ready, 1);

    // JR to a misaligned target
    accept({6'h00, 5'd4, 15'd0, 6'h08}, 32'h00400400, 32'h00400002, 0, 8, 1, 0, 0, 0, "jr");
`ifdef BR_ALIGN_CHECK_EN
    exp_q.push_back('{1'b0, 1'b1, EXC});
`else
    exp_q.push_back('{1'b1, 1'b0, 32'h00400002});
`endif
    chk("jr_bv", branch_valid, 1);
    handshake("jr");

    // JALR links to rd
    accept({6'h00, 5'd4, 5'd0, 5'd12, 5'd0, 6'h09}, 32'h00400500, 32'h00400010, 0, 9, 1, 1, 12, 32'h00400508, "jalr");
    exp_q.push_back('{1'b1, 1'b0, 32'h00400010});
    handshake("jalr");

    // Non-branch instruction is dropped
    accept({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h00400600, 1, 2, 10, 1, 0, 0, 0, "add");
    chk("add_ready", in_ready, 1);
    chk("add_bv", branch_valid, 0);

    // flush beats a same-cycle accept
    flush = 1'b1;
    accept({6'h03, 26'h0000400}, 32'h80001000, 0, 0, 11, 1, 0, 0, 0, "flush_acc");
    flush = 1'b0;
    chk("flush_acc_bv", branch_valid, 0);
    chk("flush_acc_ready", in_ready, 1);

    // flush in WAIT_DS; later tag match ignored
    accept({6'h04, 5'd1, 5'd2, 16'h0004}, 32'h00400000, 1, 1, 12, 0, 0, 0, 0, "fw");
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fw_ready", in_ready, 1);
    ds(12);
    chk("fw_ds_ignored", branch_valid, 0);

    // flush in REQ
    accept({6'h04, 5'd1, 5'd2, 16'h0004}, 32'h00400000, 1, 1, 13, 1, 0, 0, 0, "fr");
    chk("fr_bv", branch_valid, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fr_bv_drop", branch_valid, 0);
    ds(13);
    chk("fr_ds_ignored", branch_valid, 0);

    // flush together with branch_ready completes the handshake
    accept({6'h02, 26'h0000100}, 32'h00400000, 0, 0, 14, 1, 0, 0, 0, "frr");
    exp_q.push_back('{1'b1, 1'b0, 32'h00000400});
    flush = 1'b1; handshake("frr"); flush = 1'b0;

    // reset in REQ
    accept({6'h04, 5'd1, 5'd2, 16'h0004}, 32'h00400000, 1, 1, 15, 1, 0, 0, 0, "rr");
    chk("rr_bv", branch_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rr_bv_drop", branch_valid, 0);
    chk("rr_ready", in_ready, 1);
    chk("rr_target", br_target, 0);
    ds(15);
    chk("rr_ds_ignored", branch_valid, 0);

    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
